btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Two-channel input conditioner directly upstream of the a/b sequence-detector FSM.
- Each channel synchronises an asynchronous raw push-button, debounces it with a per-channel state machine and counter, and emits a debounced level plus a single-cycle rising-edge pulse.
- a_pulse/b_pulse drive the detector's a/b inputs, so one physical press yields exactly one cycle of a or b.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per channel; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to accept a level change; legal range >= 2.
- Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_a_raw  input  1  raw button A, asynchronous to clk, may bounce
- btn_b_raw  input  1  raw button B, asynchronous to clk, may bounce
- a_level  output  1  debounced level of button A
- b_level  output  1  debounced level of button B
- a_pulse  output  1  one-cycle pulse on accepted press of A; feeds detector input a
- b_pulse  output  1  one-cycle pulse on accepted press of B; feeds detector input b

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All flops are posedge clk and clear asynchronously on reset.
- Reset values: all synchroniser flops 0, state IDLE, counter 0, a_level=b_level=0, a_pulse=b_pulse=0.
- Channels are identical and fully independent. Below, "sync" is the last synchroniser flop output.
- Per-channel FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE (level 0): sync=1 -> PRESS_WAIT, cnt<=1; otherwise stay, cnt<=0.
  - PRESS_WAIT (level 0):
    - sync=0 -> IDLE, cnt<=0 (bounce rejected, no pulse).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt<=0, level<=1, pulse<=1.
    - otherwise cnt<=cnt+1.
  - PRESSED (level 1): sync=0 -> RELEASE_WAIT, cnt<=1; otherwise stay.
  - RELEASE_WAIT (level 1):
    - sync=1 -> PRESSED, cnt<=0 (release bounce rejected, level stays 1).
    - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0, level<=0.
    - otherwise cnt<=cnt+1.
- Outputs: level and pulse are registered. Pulse is high for exactly one cycle, in the cycle following entry to PRESSED; it is 0 in every other cycle.
- No pulse is generated on release.
- Latency: edge 1 is the first clk edge sampling a stable raw value.
  - a_level/a_pulse rise after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Level falls after the same count from a stable release.
- Holding the button: a held button produces no further pulses. A new pulse requires a full IDLE -> PRESS_WAIT -> PRESSED pass.
- Glitch rejection: any raw glitch shorter than DEBOUNCE_CYCLES synchronised samples produces neither a level change nor a pulse.
- Simultaneous events: both channels may pulse in the same cycle; no arbitration or ordering is applied.
- Reset mid-operation: counts, states and any pending or active pulse are discarded immediately. If raw is still high when reset deasserts, a pulse follows only after a full SYNC_STAGES+DEBOUNCE_CYCLES of stable high, counted from the first edge after deassertion.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.

Test Plan:
(Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted.)
- Clean press: btn_a_raw 0->1 held 20 cycles -> a_level and a_pulse rise after edge 6; a_pulse high exactly 1 cycle; a_level stays 1; b outputs stay 0.
- Bounce rejection: btn_a_raw toggles 1,0,1,0,1 on successive cycles, then holds 1 -> no pulse during bouncing; exactly one a_pulse, 6 edges after the final stable rise.
- Release and re-press: hold 10 cycles, release 10 cycles, press again -> a_level falls after edge 6 of the release; a second single a_pulse on the re-press; total pulses = 2.
- Release glitch: while PRESSED, drive raw 0 for 2 cycles then 1 -> a_level never drops; no additional pulse.
- Simultaneous: btn_a_raw and btn_b_raw rise on the same cycle -> a_pulse and b_pulse both high in the same single cycle after edge 6.
- Reset mid-count: raw held 1, assert reset after edge 4 for 2 cycles -> all outputs 0 immediately. After deassert, pulse occurs after edge 6 counted from deassertion. With DEBOUNCE_CYCLES=16, the clean press pulses after edge 18.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: two-channel push-button synchroniser, debouncer and press-pulse generator
//   clk        system clock
//   reset      asynchronous active-high reset
//   btn_a_raw  raw button A (asynchronous, may bounce)
//   btn_b_raw  raw button B (asynchronous, may bounce)
//   a_level    debounced level of A
//   b_level    debounced level of B
//   a_pulse    one-cycle pulse on each accepted press of A
//   b_pulse    one-cycle pulse on each accepted press of B
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a_level,
  output logic b_level,
  output logic a_pulse,
  output logic b_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] pulse;
  assign raw = {btn_b_raw, btn_a_raw};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic sync;
    logic lvl;
    logic pls;
    state_t state;
    logic [CW-1:0] cnt;
    assign sync = sync_q[SYNC_STAGES-1];
    // cnt holds how many consecutive samples have disagreed with the accepted level
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
        state  <= IDLE;
        cnt    <= '0;
        lvl    <= 1'b0;
        pls    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[c]};
        pls    <= 1'b0;
        case (state)
          IDLE: begin
            state <= sync ? PRESS_WAIT : IDLE;
            cnt   <= sync ? CW'(1) : '0;
          end
          PRESS_WAIT:
            if (!sync) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= PRESSED;
              cnt   <= '0;
              lvl   <= 1'b1;
              pls   <= 1'b1;
            end else
              cnt <= cnt + 1'b1;
          PRESSED:
            if (!sync) begin
              state <= RELEASE_WAIT;
              cnt   <= CW'(1);
            end
          RELEASE_WAIT:
            if (sync) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= IDLE;
              cnt   <= '0;
              lvl   <= 1'b0;
            end else
              cnt <= cnt + 1'b1;
          default: begin
            state <= IDLE;
            cnt   <= '0;
            lvl   <= 1'b0;
          end
        endcase
      end
    end
    assign level[c] = lvl;
    assign pulse[c] = pls;
  end
  assign a_level = level[0];
  assign b_level = level[1];
  assign a_pulse = pulse[0];
  assign b_pulse = pulse[1];
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and randomized checks of btn_conditioner against a run-length debounce model
module tb_btn_conditioner;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0, b = 1'b0, a16 = 1'b0, b16 = 1'b0;
  logic a_level, b_level, a_pulse, b_pulse;
  logic a_level16, b_level16, a_pulse16, b_pulse16;
  logic [3:0] lv, pl, prev_lv;
  int checks = 0;
  int failures = 0;
  int edge_n;
  int first_pulse[4];
  int fall_edge[4];
  int pulse_cnt[4];
  logic [S-1:0] m_hist[4];
  logic m_level[4];
  logic m_pulse[4];
  int m_run[4];
  int m_d[4] = '{4, 4, 16, 16};
  always #5 clk = ~clk;
  btn_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_a_raw(a), .btn_b_raw(b),
    .a_level(a_level), .b_level(b_level), .a_pulse(a_pulse), .b_pulse(b_pulse));
  btn_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(16)) dut16 (
    .clk(clk), .reset(reset), .btn_a_raw(a16), .btn_b_raw(b16),
    .a_level(a_level16), .b_level(b_level16), .a_pulse(a_pulse16), .b_pulse(b_pulse16));
  assign lv = {b_level16, a_level16, b_level, a_level};
  assign pl = {b_pulse16, a_pulse16, b_pulse, a_pulse};
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask
  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '0;
      m_level[i] = 1'b0;
      m_pulse[i] = 1'b0;
      m_run[i] = 0;
    end
  endtask
  // A level change is accepted once m_d consecutive synchronised samples disagree with it
  task automatic model_edge(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      logic s;
      s = m_hist[i][S-1];
      m_hist[i] = {m_hist[i][S-2:0], r[i]};
      m_pulse[i] = 1'b0;
      m_run[i] = (s != m_level[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] == m_d[i]) begin
        m_level[i] = s;
        m_run[i] = 0;
        m_pulse[i] = s;
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ch%0d_level@%0d", i, edge_n), lv[i], m_level[i]);
      check($sformatf("ch%0d_pulse@%0d", i, edge_n), pl[i], m_pulse[i]);
    end
  endtask
  task automatic clear_stats();
    edge_n = 0;
    prev_lv = lv;
    for (int i = 0; i < 4; i++) begin
      first_pulse[i] = -1;
      fall_edge[i] = -1;
      pulse_cnt[i] = 0;
    end
  endtask
  task automatic step(input logic [3:0] r);
    {b16, a16, b, a} = r;
    @(posedge clk);
    #1;
    edge_n++;
    if (reset) model_clear();
    else model_edge(r);
    for (int i = 0; i < 4; i++) begin
      if (pl[i]) pulse_cnt[i]++;
      if (pl[i] && first_pulse[i] < 0) first_pulse[i] = edge_n;
      if (prev_lv[i] && !lv[i] && fall_edge[i] < 0) fall_edge[i] = edge_n;
    end
    prev_lv = lv;
    check_all();
  endtask
  task automatic reset_dut(input logic [3:0] r, input int edges);
    reset = 1'b1;
    #1;
    model_clear();
    check_int("reset_levels", int'(lv), 0);
    check_int("reset_pulses", int'(pl), 0);
    repeat (edges) step(r);
    reset = 1'b0;
    clear_stats();
  endtask
  initial begin
    int h[4];
    logic [3:0] cur;
    logic [3:0] r;
    #2;
    reset_dut(4'b0000, 2);
    // clean press on A of both instances
    repeat (20) step(4'b0101);
    check_int("clean_pulse_edge", first_pulse[0], 6);
    check_int("clean_pulse_count", pulse_cnt[0], 1);
    check("clean_level_held", lv[0], 1'b1);
    check_int("clean_b_pulses", pulse_cnt[1], 0);
    check("clean_b_level", lv[1], 1'b0);
    check_int("clean16_pulse_edge", first_pulse[2], 18);
    check_int("clean16_pulse_count", pulse_cnt[2], 1);
    // bounce then stable high; final rise on edge 5
    reset_dut(4'b0000, 2);
    step(4'b0001); step(4'b0000); step(4'b0001); step(4'b0000);
    repeat (13) step(4'b0001);
    check_int("bounce_pulse_edge", first_pulse[0], 10);
    check_int("bounce_pulse_count", pulse_cnt[0], 1);
    // release and re-press
    reset_dut(4'b0000, 2);
    repeat (10) step(4'b0001);
    repeat (10) step(4'b0000);
    check_int("release_fall_edge", fall_edge[0], 16);
    repeat (10) step(4'b0001);
    check_int("repress_pulse_count", pulse_cnt[0], 2);
    check("repress_level", lv[0], 1'b1);
    // short release glitch while pressed
    reset_dut(4'b0000, 2);
    repeat (10) step(4'b0001);
    repeat (2) step(4'b0000);
    repeat (10) step(4'b0001);
    check_int("glitch_no_fall", fall_edge[0], -1);
    check_int("glitch_pulse_count", pulse_cnt[0], 1);
    // simultaneous press on A and B
    reset_dut(4'b0000, 2);
    repeat (10) step(4'b0011);
    check_int("simul_a_edge", first_pulse[0], 6);
    check_int("simul_b_edge", first_pulse[1], 6);
    check_int("simul_a_count", pulse_cnt[0], 1);
    check_int("simul_b_count", pulse_cnt[1], 1);
    // reset in the middle of a press count, raw stays high
    reset_dut(4'b0000, 2);
    repeat (4) step(4'b0001);
    check_int("midreset_no_pulse_yet", pulse_cnt[0], 0);
    reset_dut(4'b0001, 2);
    repeat (10) step(4'b0001);
    check_int("midreset_pulse_edge", first_pulse[0], 6);
    check_int("midreset_pulse_count", pulse_cnt[0], 1);
    // randomized bouncing on all four channels with occasional resets
    reset_dut(4'b0000, 2);
    cur = '0;
    for (int i = 0; i < 4; i++) h[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (h[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          h[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 30);
        end
        h[i]--;
      end
      r = cur;
      if ($urandom_range(0, 599) == 0) reset_dut(r, $urandom_range(1, 3));
      else step(r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
